// File: rtl/skiroc_readout_sched.sv
// SKIROC readout scheduler: hands the shared readout path to each enabled chip in
// ascending order, waits for its End_Readout (with timeout), then inserts a guard gap.
module skiroc_readout_sched #(
  parameter int unsigned NUM_CHIP = 4,
  parameter int unsigned TMO_W    = 16,
  parameter int unsigned TIMEOUT  = 50000,
  parameter int unsigned GAP_CYC  = 8
) (
  input  logic                        Clk,
  input  logic                        Rst_N,
  input  logic                        In_Readout_Req,
  input  logic [NUM_CHIP-1:0]         In_Chip_Mask,
  input  logic [NUM_CHIP-1:0]         In_End_Readout,
  output logic [NUM_CHIP-1:0]         Out_Start_Readout,
  output logic [$clog2(NUM_CHIP)-1:0] Out_Sel_Chip,
  output logic                        Out_Busy,
  output logic                        Out_Done,
  output logic [NUM_CHIP-1:0]         Out_Timeout_Flags,
  output logic                        Out_Overrun
);

  localparam int unsigned SEL_W = $clog2(NUM_CHIP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_END,
    S_GAP,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CHIP-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [TMO_W-1:0]    timer_q, timer_d;
  logic [NUM_CHIP-1:0] flags_q, flags_d;
  logic [NUM_CHIP-1:0] start_q, start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic [SEL_W-1:0]    first_idx_c;
  logic [SEL_W-1:0]    next_idx_c;
  logic                has_next_c;
  logic                accept_c;
  logic                end_hit_c;
  logic                tmo_hit_c;
  logic                gap_hit_c;
  logic                timer_sat_c;

  // Lowest enabled chip of a new request, and next higher enabled chip of the latched mask
  always_comb begin
    first_idx_c = '0;
    next_idx_c  = '0;
    has_next_c  = 1'b0;
    for (int i = NUM_CHIP - 1; i >= 0; i--) begin
      if (In_Chip_Mask[i]) begin
        first_idx_c = SEL_W'(i);
      end
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_idx_c = SEL_W'(i);
        has_next_c = 1'b1;
      end
    end
  end

  assign accept_c    = In_Readout_Req && !busy_q;
  assign end_hit_c   = In_End_Readout[sel_q];
  assign tmo_hit_c   = (timer_q == TMO_W'(TIMEOUT - 1));
  assign gap_hit_c   = (timer_q == TMO_W'(GAP_CYC - 1));
  assign timer_sat_c = (timer_q == {TMO_W{1'b1}});

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept_c) state_d = (In_Chip_Mask != '0) ? S_START : S_DONE;
      S_START:    state_d = S_WAIT_END;
      S_WAIT_END: if (end_hit_c || tmo_hit_c) state_d = S_GAP;
      S_GAP:      if (gap_hit_c) state_d = has_next_c ? S_START : S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Next values of all registered outputs and datapath; timer doubles as gap counter
  always_comb begin
    mask_d  = mask_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    flags_d = flags_q;
    busy_d  = busy_q;
    ovr_d   = ovr_q;
    start_d = '0;
    done_d  = (state_q == S_DONE);

    if (In_Readout_Req && busy_q) ovr_d = 1'b1;
    if (done_q) busy_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          mask_d  = In_Chip_Mask;
          flags_d = '0;
          ovr_d   = 1'b0;
          busy_d  = 1'b1;
          if (In_Chip_Mask != '0) sel_d = first_idx_c;
        end
      end
      S_START: begin
        start_d = NUM_CHIP'(1) << sel_q;
        timer_d = '0;
      end
      S_WAIT_END: begin
        if (end_hit_c) begin
          timer_d = '0;
        end else if (tmo_hit_c) begin
          flags_d[sel_q] = 1'b1;
          timer_d        = '0;
        end else if (!timer_sat_c) begin
          timer_d = timer_q + TMO_W'(1);
        end
      end
      S_GAP: begin
        if (gap_hit_c) begin
          timer_d = '0;
          if (has_next_c) sel_d = next_idx_c;
        end else if (!timer_sat_c) begin
          timer_d = timer_q + TMO_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      mask_q  <= '0;
      sel_q   <= '0;
      timer_q <= '0;
      flags_q <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      flags_q <= flags_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Out_Start_Readout = start_q;
  assign Out_Sel_Chip      = sel_q;
  assign Out_Busy          = busy_q;
  assign Out_Done          = done_q;
  assign Out_Timeout_Flags = flags_q;
  assign Out_Overrun       = ovr_q;

endmodule

// File: tb/tb_skiroc_readout_sched.sv
// Bench for skiroc_readout_sched: a timeline model predicts, per cycle, every output
// for each readout sequence while an ASIC responder answers start pulses.
module tb_skiroc_readout_sched;

  localparam int unsigned NC      = 4;
  localparam int unsigned SW      = 2;
  localparam int          TIMEOUT = 20;
  localparam int          GAP     = 4;

  logic          Clk;
  logic          Rst_N;
  logic          In_Readout_Req;
  logic [NC-1:0] In_Chip_Mask;
  logic [NC-1:0] In_End_Readout;
  logic [NC-1:0] Out_Start_Readout;
  logic [SW-1:0] Out_Sel_Chip;
  logic          Out_Busy;
  logic          Out_Done;
  logic [NC-1:0] Out_Timeout_Flags;
  logic          Out_Overrun;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          cyc = 0;
  int          dly [NC];
  int          prev_sel = 0;

  skiroc_readout_sched #(
    .NUM_CHIP (NC),
    .TMO_W    (16),
    .TIMEOUT  (TIMEOUT),
    .GAP_CYC  (GAP)
  ) dut (
    .Clk               (Clk),
    .Rst_N             (Rst_N),
    .In_Readout_Req    (In_Readout_Req),
    .In_Chip_Mask      (In_Chip_Mask),
    .In_End_Readout    (In_End_Readout),
    .Out_Start_Readout (Out_Start_Readout),
    .Out_Sel_Chip      (Out_Sel_Chip),
    .Out_Busy          (Out_Busy),
    .Out_Done          (Out_Done),
    .Out_Timeout_Flags (Out_Timeout_Flags),
    .Out_Overrun       (Out_Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int unsigned all_outs();
    return 32'({Out_Start_Readout, Out_Sel_Chip, Out_Busy, Out_Done, Out_Timeout_Flags, Out_Overrun});
  endfunction

  // Random End delay: never, exactly at timeout, just after timeout, or a normal latency
  function automatic int pick_dly();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return TIMEOUT;
    if (r == 2) return TIMEOUT + int'($urandom_range(1, 2));
    return int'($urandom_range(2, 8));
  endfunction

  // One request from IDLE. ovr_mode: 0 none, 1 request during first WAIT_END, 2 request in the Done cycle.
  // Called at a negedge; dly[c] is the End latency (edges after the start pulse), 0 = never.
  task automatic run_seq(input logic [NC-1:0] mask, input int ovr_mode, input bit early, input bit spur_en);
    int k, t, e, exp_done, ovr_drive, ovr_cyc, early_at, early_chip, spur_at, spur_chip, last, sel_exp, mode;
    int exp_start [NC];
    int exp_entry [NC];
    int flag_cyc [NC];
    int end_at [NC];
    logic [NC-1:0] start_exp, flags_exp, end_v;

    k = cyc + 1;
    t = k;
    last = -1;
    early_chip = 0;
    for (int c = NC - 1; c >= 0; c--) if (mask[c]) early_chip = c;
    for (int c = 0; c < NC; c++) begin
      exp_start[c] = -1;
      exp_entry[c] = -1;
      flag_cyc[c]  = -1;
      end_at[c]    = -1;
    end
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) begin
        exp_entry[c] = t;
        exp_start[c] = t + 1;
        if (dly[c] == 0 || dly[c] > TIMEOUT) begin
          e = t + 1 + TIMEOUT;
          flag_cyc[c] = e;
        end else begin
          e = t + 1 + dly[c];
        end
        t = e + GAP;
        last = c;
      end
    end
    exp_done = t + 1;
    mode = (mask == '0 && ovr_mode == 1) ? 2 : ovr_mode;
    ovr_drive = (mode == 1) ? k + 2 : (mode == 2) ? exp_done : -1;
    ovr_cyc   = (ovr_drive < 0) ? -1 : ovr_drive + 1;
    early_at  = (early && mask != '0) ? k : -1;
    spur_at   = -1;
    spur_chip = 0;

    In_Readout_Req = 1'b1;
    In_Chip_Mask   = mask;
    do begin
      @(negedge Clk);
      start_exp = '0;
      flags_exp = '0;
      sel_exp   = prev_sel;
      for (int c = 0; c < NC; c++) begin
        if (exp_start[c] == cyc) start_exp[c] = 1'b1;
        if (flag_cyc[c] >= 0 && cyc >= flag_cyc[c]) flags_exp[c] = 1'b1;
        if (exp_entry[c] >= 0 && cyc >= exp_entry[c]) sel_exp = c;
      end
      chk("start", 32'(Out_Start_Readout), 32'(start_exp));
      chk("sel",   32'(Out_Sel_Chip), 32'(sel_exp));
      chk("busy",  32'(Out_Busy), 32'(cyc >= k && cyc <= exp_done));
      chk("done",  32'(Out_Done), 32'(cyc == exp_done));
      chk("flags", 32'(Out_Timeout_Flags), 32'(flags_exp));
      chk("ovr",   32'(Out_Overrun), 32'(ovr_cyc >= 0 && cyc >= ovr_cyc));

      end_v = '0;
      for (int c = 0; c < NC; c++) if (end_at[c] == cyc) end_v[c] = 1'b1;
      if (early_at == cyc) end_v[early_chip] = 1'b1;
      if (spur_at == cyc) end_v[spur_chip] = 1'b1;
      for (int c = 0; c < NC; c++) begin
        if (Out_Start_Readout[c]) begin
          if (dly[c] != 0) end_at[c] = cyc + dly[c] - 1;
          if (spur_en) begin
            spur_at   = cyc + 1;
            spur_chip = (c + 2) % NC;
          end
        end
      end
      In_End_Readout = end_v;
      In_Readout_Req = (cyc == ovr_drive);
      if (cyc == k) In_Chip_Mask = NC'($urandom);
    end while (cyc < exp_done + 3);
    In_Readout_Req = 1'b0;
    In_End_Readout = '0;
    if (last >= 0) prev_sel = last;
  endtask

  initial begin
    int n;
    Rst_N          = 1'b0;
    In_Readout_Req = 1'b0;
    In_Chip_Mask   = '0;
    In_End_Readout = '0;
    for (int c = 0; c < NC; c++) dly[c] = 5;

    repeat (3) @(negedge Clk);
    chk("rst_outs", all_outs(), 0);
    Rst_N = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      chk("idle_outs", all_outs(), 0);
    end

    // Full mask, fixed latency
    run_seq(4'b1111, 0, 1'b0, 1'b0);
    // Sparse mask with spurious ends on non-selected chips
    for (int c = 0; c < NC; c++) dly[c] = pick_dly();
    run_seq(4'b1010, 0, 1'b0, 1'b1);
    // Chip 2 never ends
    dly = '{5, 5, 0, 5};
    run_seq(4'b1111, 0, 1'b0, 1'b0);
    // End exactly at the timeout cycle counts as an end
    dly = '{3, TIMEOUT, 4, 0};
    run_seq(4'b1111, 0, 1'b0, 1'b0);
    // Empty mask, request in the Done cycle
    run_seq(4'b0000, 2, 1'b0, 1'b0);
    // Early end in START, spurious end on chip 3 while chip 1 is served
    dly = '{5, 6, 5, 5};
    run_seq(4'b0010, 0, 1'b1, 1'b1);
    // Overrun during WAIT_END
    for (int c = 0; c < NC; c++) dly[c] = 4;
    run_seq(4'b1111, 1, 1'b0, 1'b0);

    // Abort by reset during WAIT_END of chip 2
    In_Readout_Req = 1'b1;
    In_Chip_Mask   = 4'b1100;
    @(negedge Clk);
    In_Readout_Req = 1'b0;
    n = 0;
    while (Out_Start_Readout == '0 && n < 8) begin
      @(negedge Clk);
      n++;
    end
    chk("abort_start", 32'(Out_Start_Readout), 32'(4'b0100));
    In_Readout_Req = 1'b1;
    @(negedge Clk);
    In_Readout_Req = 1'b0;
    @(negedge Clk);
    chk("abort_ovr",  32'(Out_Overrun), 1);
    chk("abort_sel",  32'(Out_Sel_Chip), 2);
    chk("abort_busy", 32'(Out_Busy), 1);
    #2 Rst_N = 1'b0;
    #1 chk("abort_rst_outs", all_outs(), 0);
    @(negedge Clk);
    chk("abort_hold_outs", all_outs(), 0);
    Rst_N = 1'b1;
    prev_sel = 0;
    @(negedge Clk);
    dly = '{5, 3, 7, 5};
    run_seq(4'b0110, 0, 1'b0, 1'b0);

    // Randomized sequences
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < NC; c++) dly[c] = pick_dly();
      run_seq(NC'($urandom), int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
      repeat (int'($urandom_range(0, 3))) @(negedge Clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
